// File: rtl/ws2812_loader.sv
// ws2812_loader: gathers an R,G,B byte stream into per-LED {G,R,B} words
// and hands each word to a WS2812 driver with a one-cycle write strobe.
// A byte flagged with byte_sof always (re)starts a frame at LED 0.
// Optional feature macro: WS2812_BRIGHTNESS_EN -- scales every accepted byte
// by brightness/256 and adds one pipeline cycle before the write.
module ws2812_loader #(
  parameter int NUM_LEDS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  input  logic        byte_sof,
  output logic        byte_ready,
  input  logic [7:0]  brightness,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        write,
  output logic        frame_done,
  output logic        overflow
);

  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [IDX_W-1:0] LAST_LED = IDX_W'(NUM_LEDS - 1);

  // ST_PIPE is only reachable when the brightness stage is built in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PIPE,
    ST_WRITE,
    ST_DRAIN
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       byte_idx;
  logic [IDX_W-1:0] led_idx;
  logic [7:0]       r_q;
  logic [7:0]       g_q;
  logic [7:0]       b_q;
  logic [7:0]       byte_val;
  logic             accept;
  logic             last_led;

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] unused_frac;
  // Scale the incoming byte; brightness is taken in the accept cycle.
  assign {byte_val, unused_frac} = byte_data * brightness;
`else
  logic unused_brightness;
  assign byte_val          = byte_data;
  assign unused_brightness = ^brightness;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, handshake and write strobe.
  always_comb begin
    state_next = state;
    byte_ready = reset_n && (state inside {ST_IDLE, ST_COLLECT, ST_DRAIN});
    accept     = byte_valid && byte_ready;
    write      = (state == ST_WRITE);
    last_led   = (led_idx == LAST_LED);
    unique case (state)
      ST_IDLE, ST_DRAIN: begin
        if (accept && byte_sof) begin
          state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (accept && !byte_sof && byte_idx == 2'd2) begin
`ifdef WS2812_BRIGHTNESS_EN
          state_next = ST_PIPE;
`else
          state_next = ST_WRITE;
`endif
        end
      end
      ST_PIPE: begin
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        state_next = last_led ? ST_DRAIN : ST_COLLECT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Byte capture, LED indexing, output word and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx   <= '0;
      led_idx    <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      rgb_data   <= '0;
      led_num    <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= (state == ST_WRITE) && last_led;

      if (accept) begin
        if (byte_sof) begin
          // A start-of-frame byte always becomes R of LED 0, discarding
          // any partially collected LED.
          r_q      <= byte_val;
          byte_idx <= 2'd1;
          led_idx  <= '0;
        end else if (state == ST_COLLECT) begin
          unique case (byte_idx)
            2'd0:    r_q <= byte_val;
            2'd1:    g_q <= byte_val;
            default: b_q <= byte_val;
          endcase
          byte_idx <= (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;
        end else if (state == ST_DRAIN) begin
          overflow <= 1'b1;
        end
      end

      if (state == ST_WRITE) begin
        led_idx <= last_led ? '0 : led_idx + 1'b1;
      end

      // The word is latched on entry to WRITE; when entering straight from
      // COLLECT the blue byte is taken from the input rather than b_q.
      if (state_next == ST_WRITE) begin
        rgb_data <= {g_q, r_q, (state == ST_PIPE) ? b_q : byte_val};
        led_num  <= 8'(led_idx);
      end
    end
  end

endmodule
